// File: rtl/cache_axi_arbiter_pkg.sv
// Shared definitions for the ICache/DCache AXI read arbiter: FSM state
// encoding and the AXI size/burst constants both caches issue.
package cache_axi_arbiter_pkg;

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_AR0  = 3'd1;
    localparam logic [2:0] ST_AR1  = 3'd2;
    localparam logic [2:0] ST_R0   = 3'd3;
    localparam logic [2:0] ST_R1   = 3'd4;

    typedef enum logic [2:0] {
        IDLE = ST_IDLE,
        AR0  = ST_AR0,
        AR1  = ST_AR1,
        R0   = ST_R0,
        R1   = ST_R1
    } arb_state_e;

    // Both caches fetch full 32-bit words in incrementing bursts.
    localparam logic [2:0] AXI_SIZE_4B    = 3'b010;
    localparam logic [1:0] AXI_BURST_INCR = 2'b01;

endpackage

// File: rtl/cache_axi_arbiter.sv
// Two-master (ICache s0 / DCache s1) to one AXI read port arbiter with
// round-robin tie-break, one outstanding burst and a sticky beat-count check.
module cache_axi_arbiter
    import cache_axi_arbiter_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int LEN_W  = 4,
    parameter int ID_W   = 4
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic [ID_W-1:0]   s0_arid,
    input  logic [ADDR_W-1:0] s0_araddr,
    input  logic [LEN_W-1:0]  s0_arlen,
    input  logic              s0_arvalid,
    output logic              s0_arready,
    output logic [ID_W-1:0]   s0_rid,
    output logic [DATA_W-1:0] s0_rdata,
    output logic [1:0]        s0_rresp,
    output logic              s0_rlast,
    output logic              s0_rvalid,
    input  logic              s0_rready,
    input  logic [ID_W-1:0]   s1_arid,
    input  logic [ADDR_W-1:0] s1_araddr,
    input  logic [LEN_W-1:0]  s1_arlen,
    input  logic              s1_arvalid,
    output logic              s1_arready,
    output logic [ID_W-1:0]   s1_rid,
    output logic [DATA_W-1:0] s1_rdata,
    output logic [1:0]        s1_rresp,
    output logic              s1_rlast,
    output logic              s1_rvalid,
    input  logic              s1_rready,
    output logic [ID_W-1:0]   m_arid,
    output logic [ADDR_W-1:0] m_araddr,
    output logic [LEN_W-1:0]  m_arlen,
    output logic              m_arvalid,
    input  logic              m_arready,
    input  logic [ID_W-1:0]   m_rid,
    input  logic [DATA_W-1:0] m_rdata,
    input  logic [1:0]        m_rresp,
    input  logic              m_rlast,
    input  logic              m_rvalid,
    output logic              m_rready,
    output logic              busy,
    output logic              len_err
);

    arb_state_e        state_q, state_d;
    logic              last_grant_q, last_grant_d;
    logic [LEN_W:0]    beat_cnt_q, beat_cnt_d;
    logic [LEN_W-1:0]  exp_len_q, exp_len_d;
    logic              len_err_q, len_err_d;

    logic              sel_s1;
    logic              g_arvalid, g_rready;
    logic [ID_W-1:0]   g_arid;
    logic [ADDR_W-1:0] g_araddr;
    logic [LEN_W-1:0]  g_arlen;
    logic              last_exp;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q      <= IDLE;
            last_grant_q <= 1'b0;
            beat_cnt_q   <= '0;
            exp_len_q    <= '0;
            len_err_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            beat_cnt_q   <= beat_cnt_d;
            exp_len_q    <= exp_len_d;
            len_err_q    <= len_err_d;
        end
    end

    // Granted side is a pure function of state; m_rid is never decoded.
    assign sel_s1    = (state_q == AR1) || (state_q == R1);
    assign g_arvalid = sel_s1 ? s1_arvalid : s0_arvalid;
    assign g_arid    = sel_s1 ? s1_arid    : s0_arid;
    assign g_araddr  = sel_s1 ? s1_araddr  : s0_araddr;
    assign g_arlen   = sel_s1 ? s1_arlen   : s0_arlen;
    assign g_rready  = sel_s1 ? s1_rready  : s0_rready;
    assign last_exp  = (beat_cnt_q == {1'b0, exp_len_q});

    assign s0_rid   = m_rid;
    assign s0_rdata = m_rdata;
    assign s0_rresp = m_rresp;
    assign s0_rlast = m_rlast;
    assign s1_rid   = m_rid;
    assign s1_rdata = m_rdata;
    assign s1_rresp = m_rresp;
    assign s1_rlast = m_rlast;

    assign busy    = (state_q != IDLE);
    assign len_err = len_err_q;

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        beat_cnt_d   = beat_cnt_q;
        exp_len_d    = exp_len_q;
        len_err_d    = len_err_q;
        m_arid       = '0;
        m_araddr     = '0;
        m_arlen      = '0;
        m_arvalid    = 1'b0;
        s0_arready   = 1'b0;
        s1_arready   = 1'b0;
        s0_rvalid    = 1'b0;
        s1_rvalid    = 1'b0;
        // Outside a read burst any stray R beats are swallowed.
        m_rready     = 1'b1;

        unique case (state_q)
            IDLE: begin
                if (s0_arvalid && s1_arvalid)
                    state_d = last_grant_q ? AR0 : AR1;
                else if (s0_arvalid)
                    state_d = AR0;
                else if (s1_arvalid)
                    state_d = AR1;
            end
            AR0, AR1: begin
                m_arid    = g_arid;
                m_araddr  = g_araddr;
                m_arlen   = g_arlen;
                m_arvalid = g_arvalid;
                if (sel_s1) s1_arready = m_arready;
                else        s0_arready = m_arready;
                if (!g_arvalid) begin
                    state_d = IDLE;
                end else if (m_arready) begin
                    state_d      = sel_s1 ? R1 : R0;
                    beat_cnt_d   = '0;
                    exp_len_d    = g_arlen;
                    last_grant_d = sel_s1;
                end
            end
            R0, R1: begin
                if (sel_s1) s1_rvalid = m_rvalid;
                else        s0_rvalid = m_rvalid;
                m_rready = g_rready;
                if (m_rvalid && g_rready) begin
                    beat_cnt_d = beat_cnt_q + 1'b1;
                    if (m_rlast) begin
                        state_d = IDLE;
                        if (!last_exp) len_err_d = 1'b1;
                    end else if (last_exp) begin
                        len_err_d = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_cache_axi_arbiter.sv
// Directed bench for cache_axi_arbiter: grant order, abort, burst routing,
// length-error flag, reset mid-burst and R back-pressure.
module tb_cache_axi_arbiter;

    logic        clk = 1'b0;
    logic        resetn;
    logic [3:0]  s0_arid, s1_arid, m_arid, s0_rid, s1_rid, m_rid;
    logic [31:0] s0_araddr, s1_araddr, m_araddr;
    logic [3:0]  s0_arlen, s1_arlen, m_arlen;
    logic        s0_arvalid, s1_arvalid, m_arvalid;
    logic        s0_arready, s1_arready, m_arready;
    logic [31:0] s0_rdata, s1_rdata, m_rdata;
    logic [1:0]  s0_rresp, s1_rresp, m_rresp;
    logic        s0_rlast, s1_rlast, m_rlast;
    logic        s0_rvalid, s1_rvalid, m_rvalid;
    logic        s0_rready, s1_rready, m_rready;
    logic        busy, len_err;

    int n_vec = 0;
    int n_err = 0;

    localparam logic [31:0] A0 = 32'h1FC0_0000;
    localparam logic [31:0] A1 = 32'h0000_1000;

    cache_axi_arbiter dut (
        .clk(clk), .resetn(resetn),
        .s0_arid(s0_arid), .s0_araddr(s0_araddr), .s0_arlen(s0_arlen),
        .s0_arvalid(s0_arvalid), .s0_arready(s0_arready),
        .s0_rid(s0_rid), .s0_rdata(s0_rdata), .s0_rresp(s0_rresp),
        .s0_rlast(s0_rlast), .s0_rvalid(s0_rvalid), .s0_rready(s0_rready),
        .s1_arid(s1_arid), .s1_araddr(s1_araddr), .s1_arlen(s1_arlen),
        .s1_arvalid(s1_arvalid), .s1_arready(s1_arready),
        .s1_rid(s1_rid), .s1_rdata(s1_rdata), .s1_rresp(s1_rresp),
        .s1_rlast(s1_rlast), .s1_rvalid(s1_rvalid), .s1_rready(s1_rready),
        .m_arid(m_arid), .m_araddr(m_araddr), .m_arlen(m_arlen),
        .m_arvalid(m_arvalid), .m_arready(m_arready),
        .m_rid(m_rid), .m_rdata(m_rdata), .m_rresp(m_rresp),
        .m_rlast(m_rlast), .m_rvalid(m_rvalid), .m_rready(m_rready),
        .busy(busy), .len_err(len_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset();
        resetn = 1'b0;
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_len_err", len_err, 0);
        chk("rst_m_arvalid", m_arvalid, 0);
        chk("rst_s0_arready", s0_arready, 0);
        chk("rst_s1_arready", s1_arready, 0);
        chk("rst_s0_rvalid", s0_rvalid, 0);
        chk("rst_s1_rvalid", s1_rvalid, 0);
        chk("rst_m_rready", m_rready, 1);
        tick();
        resetn = 1'b1;
    endtask

    task automatic req(input int s, input logic [31:0] addr, input logic [3:0] len);
        if (s == 0) begin
            s0_arvalid = 1'b1; s0_araddr = addr; s0_arlen = len; s0_arid = 4'h2;
        end else begin
            s1_arvalid = 1'b1; s1_araddr = addr; s1_arlen = len; s1_arid = 4'h9;
        end
    endtask

    // From IDLE with requests pending: expect side s granted, then handshake.
    task automatic ar_hs(input int s, input logic [31:0] addr, input logic [3:0] len);
        tick();
        chk("ar_valid", m_arvalid, 1);
        chk("ar_addr", m_araddr, addr);
        chk("ar_len", m_arlen, len);
        chk("ar_id", m_arid, (s == 0) ? 4'h2 : 4'h9);
        chk("ar_busy", busy, 1);
        m_arready = 1'b1;
        #1;
        chk("arready_g", (s == 0) ? s0_arready : s1_arready, 1);
        chk("arready_ng", (s == 0) ? s1_arready : s0_arready, 0);
        tick();
        if (s == 0) s0_arvalid = 1'b0; else s1_arvalid = 1'b0;
        m_arready = 1'b0;
    endtask

    task automatic burst(input int s, input int first, input int n, input int last_at);
        for (int i = first; i < first + n; i++) begin
            m_rvalid  = 1'b1;
            m_rdata   = 32'hD000_0000 | 32'(s << 16) | 32'(i);
            m_rid     = 4'(5 + s);
            m_rlast   = (i == last_at);
            s0_rready = 1'b1;
            s1_rready = 1'b1;
            #1;
            chk("rvalid_g", (s == 0) ? s0_rvalid : s1_rvalid, 1);
            chk("rvalid_ng", (s == 0) ? s1_rvalid : s0_rvalid, 0);
            chk("rdata", (s == 0) ? s0_rdata : s1_rdata, 32'hD000_0000 | 32'(s << 16) | 32'(i));
            chk("rid", (s == 0) ? s0_rid : s1_rid, 4'(5 + s));
            chk("m_rready", m_rready, 1);
            chk("ar_quiet", s0_arready | s1_arready | m_arvalid, 0);
            tick();
        end
        m_rvalid = 1'b0;
        m_rlast  = 1'b0;
    endtask

    initial begin
        resetn = 1'b0;
        {s0_arid, s0_araddr, s0_arlen, s0_arvalid, s0_rready} = '0;
        {s1_arid, s1_araddr, s1_arlen, s1_arvalid, s1_rready} = '0;
        {m_arready, m_rid, m_rdata, m_rresp, m_rlast, m_rvalid} = '0;
        do_reset();

        // 16-beat ICache fill, slave ready on the second AR cycle
        req(0, A0, 4'd15);
        #1;
        chk("idle_no_ar", m_arvalid, 0);
        tick();
        chk("ar0_valid", m_arvalid, 1);
        chk("ar0_addr", m_araddr, A0);
        chk("ar0_len", m_arlen, 15);
        chk("ar0_wait_rdy", s0_arready, 0);
        chk("ar0_rdy_ng", s1_arready, 0);
        tick();
        chk("ar0_still", m_arvalid, 1);
        m_arready = 1'b1;
        #1;
        chk("ar0_rdy", s0_arready, 1);
        tick();
        s0_arvalid = 1'b0;
        m_arready  = 1'b0;
        burst(0, 0, 16, 15);
        #1;
        chk("fill_idle", busy, 0);
        chk("fill_len_err", len_err, 0);

        // Tie after reset goes to s1, then s0, then s1 again
        do_reset();
        req(0, A0, 4'd1);
        req(1, A1, 4'd3);
        ar_hs(1, A1, 4'd3);
        #1;
        chk("s0_wait_in_r1", s0_arready, 0);
        burst(1, 0, 4, 3);
        ar_hs(0, A0, 4'd1);
        burst(0, 0, 2, 1);
        req(0, A0 + 32'h40, 4'd0);
        req(1, A1 + 32'h40, 4'd0);
        ar_hs(1, A1 + 32'h40, 4'd0);
        burst(1, 0, 1, 0);
        ar_hs(0, A0 + 32'h40, 4'd0);
        burst(0, 0, 1, 0);

        // s0 aborts before AR handshake; pending s1 is then served
        do_reset();
        req(0, A0, 4'd2);
        tick();
        chk("abort_ar", m_arvalid, 1);
        s0_arvalid = 1'b0;
        req(1, A1, 4'd0);
        #1;
        chk("abort_comb", m_arvalid, 0);
        tick();
        chk("abort_idle", busy, 0);
        chk("abort_no_ar", m_arvalid, 0);
        ar_hs(1, A1, 4'd0);
        burst(1, 0, 1, 0);
        #1;
        chk("single_len_err", len_err, 0);

        // s1 abort must leave last_grant at s0, so next tie still goes to s1
        do_reset();
        req(1, A1, 4'd0);
        tick();
        s1_arvalid = 1'b0;
        tick();
        chk("abort1_idle", busy, 0);
        req(0, A0, 4'd0);
        req(1, A1, 4'd0);
        ar_hs(1, A1, 4'd0);
        burst(1, 0, 1, 0);
        ar_hs(0, A0, 4'd0);
        burst(0, 0, 1, 0);

        // Early rlast sets the sticky error
        do_reset();
        req(0, A0, 4'd3);
        ar_hs(0, A0, 4'd3);
        burst(0, 0, 3, 2);
        #1;
        chk("short_err", len_err, 1);
        chk("short_idle", busy, 0);
        req(1, A1, 4'd0);
        ar_hs(1, A1, 4'd0);
        burst(1, 0, 1, 0);
        #1;
        chk("err_sticky", len_err, 1);
        chk("err_idle", busy, 0);

        // Missing rlast: error at the expected last beat, stay until rlast
        do_reset();
        req(0, A0, 4'd1);
        ar_hs(0, A0, 4'd1);
        burst(0, 0, 2, -1);
        #1;
        chk("long_err", len_err, 1);
        chk("long_busy", busy, 1);
        burst(0, 2, 1, 2);
        #1;
        chk("long_done", busy, 0);

        // Reset on beat 5 of 16; remaining beats drained
        do_reset();
        req(0, A0, 4'd15);
        ar_hs(0, A0, 4'd15);
        burst(0, 0, 4, -1);
        m_rvalid = 1'b1;
        m_rdata  = 32'hD000_0004;
        resetn   = 1'b0;
        #1;
        chk("mid_rst_rvalid", s0_rvalid, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_arvalid", m_arvalid, 0);
        chk("mid_rst_rready", m_rready, 1);
        chk("mid_rst_arready", s0_arready, 0);
        tick();
        resetn = 1'b1;
        for (int i = 5; i < 16; i++) begin
            m_rvalid = 1'b1;
            m_rlast  = (i == 15);
            #1;
            chk("drain_rready", m_rready, 1);
            chk("drain_s0_rvalid", s0_rvalid, 0);
            chk("drain_s1_rvalid", s1_rvalid, 0);
            chk("drain_busy", busy, 0);
            tick();
        end
        m_rvalid = 1'b0;
        m_rlast  = 1'b0;
        req(1, A1, 4'd1);
        ar_hs(1, A1, 4'd1);
        burst(1, 0, 2, 1);
        #1;
        chk("post_rst_err", len_err, 0);
        chk("post_rst_idle", busy, 0);

        // s1_rready low for 3 cycles mid-burst
        req(1, A1, 4'd7);
        ar_hs(1, A1, 4'd7);
        burst(1, 0, 3, -1);
        for (int k = 0; k < 3; k++) begin
            m_rvalid  = 1'b1;
            m_rdata   = 32'hD001_0003;
            s1_rready = 1'b0;
            #1;
            chk("stall_rready", m_rready, 0);
            chk("stall_rvalid", s1_rvalid, 1);
            tick();
        end
        burst(1, 3, 5, 7);
        #1;
        chk("stall_len_err", len_err, 0);
        chk("stall_idle", busy, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/cache_axi_arbiter.md
CACHE_AXI_ARBITER -- requirements
Module: cache_axi_arbiter

Interface
REQ-001 Parameter ADDR_W, default 32: AR address width.
REQ-002 Parameter DATA_W, default 32: R data width.
REQ-003 Parameter LEN_W, default 4: arlen width, AXI3 bursts of up to 16 beats.
REQ-004 Parameter ID_W, default 4: arid/rid width.
REQ-005 Port `clk`, input, 1 bit: single clock. Reset is asynchronous and active-low.
REQ-006 Port `resetn`, input, 1 bit: asynchronous active-low reset.
REQ-007 Ports `s0_arid`, `s0_araddr`, `s0_arlen`, `s0_arvalid`: inputs, widths ID_W/ADDR_W/LEN_W/1. ICache AR request.
REQ-008 Port `s0_arready`: output, 1 bit. ICache AR ready.
REQ-009 Ports `s0_rid`, `s0_rdata`, `s0_rresp`, `s0_rlast`, `s0_rvalid`: outputs, widths ID_W/DATA_W/2/1/1. ICache R channel.
REQ-010 Port `s0_rready`: input, 1 bit. ICache R ready.
REQ-011 Ports `s1_*`: same set and widths as REQ-007..010, for the DCache.
REQ-012 Ports `m_arid`, `m_araddr`, `m_arlen`, `m_arvalid`: outputs. Shared AXI AR channel.
REQ-013 Port `m_arready`: input. Shared AXI AR ready.
REQ-014 Ports `m_rid`, `m_rdata`, `m_rresp`, `m_rlast`, `m_rvalid`: inputs. Shared AXI R channel.
REQ-015 Port `m_rready`: output. Shared AXI R ready.
REQ-016 Port `busy`: output, 1 bit. High in any state other than IDLE.
REQ-017 Port `len_err`: output, 1 bit. Sticky flag: burst beat count did not match arlen.

Function
REQ-018 The FSM SHALL have five states: IDLE, AR0, AR1, R0, R1.
REQ-019 IDLE, one requester asserting arvalid: go to that requester's AR state next cycle.
REQ-020 IDLE, both requesters asserting arvalid: grant the requester not recorded in last_grant (round-robin); after reset, s1 wins the first tie.
REQ-021 ARx: drive m_ar* and m_arvalid combinationally from sx_ar*; drive sx_arready = m_arready.
REQ-022 ARx, handshake (sx_arvalid && m_arready): go to Rx, load beat_cnt=0, latch exp_len=sx_arlen, update last_grant=x.
REQ-023 ARx, sx_arvalid deasserted before handshake (cache abort): return to IDLE; last_grant is unchanged; no AR is issued.
REQ-024 Rx: route m_r* to sx_r*, route m_rready = sx_rready; on every m_rvalid && m_rready, beat_cnt increments by 1.
REQ-025 Rx, m_rvalid && m_rready && m_rlast: go to IDLE; if beat_cnt != exp_len at that beat, set len_err.
REQ-026 Rx, a beat completes with beat_cnt == exp_len but m_rlast is low: set len_err and stay in Rx until rlast.
REQ-027 Routing is by FSM state only; m_rid is forwarded unchanged and is not decoded.
REQ-028 Non-granted requester SHALL see arready=0 and rvalid=0 at all times.
REQ-029 In IDLE, m_arvalid=0 and m_rready=1, so stray beats are drained.
REQ-030 At most one outstanding transaction exists; no new AR is accepted in Rx.
REQ-031 A request from s0 arriving during R1 waits; it is granted next from IDLE by REQ-019/020.
REQ-032 Latency: IDLE to m_arvalid high is 1 cycle after the request; Rx to IDLE is 1 cycle after rlast.

Reset
REQ-033 resetn low SHALL immediately set: state=IDLE, last_grant=0, beat_cnt=0, exp_len=0, len_err=0.
REQ-034 During reset, all s*_arready, s*_rvalid and m_arvalid are 0 and busy=0.
REQ-035 Reset asserted mid-burst abandons the burst; remaining m_r beats are drained per REQ-029.

Structure
REQ-036 Shared package holds the state encoding (3-bit localparams) and the AXI size/burst constants used by both caches.
REQ-037 No sub-module; AR/R muxes and FSM live in one module of about 150-250 lines.

Verification
REQ-038 s0 arvalid with araddr=0x1FC0_0000, arlen=15; arready after 2 cycles; 16 beats -> s0 receives 16 beats, s1_rvalid=0 throughout, state returns to IDLE, len_err=0.
REQ-039 s0 and s1 request in the same cycle after reset -> s1 is granted first; after its burst completes, s0 is granted; then a further tie -> s1.
REQ-040 s0 arvalid drops after 1 cycle with m_arready=0 -> FSM returns to IDLE, m_arvalid=0 the next cycle, and a pending s1 request is granted.
REQ-041 arlen=3 and slave sends rlast on beat 2 -> len_err=1 and stays 1; arlen=0 single uncached beat -> normal completion.
REQ-042 resetn pulsed low during beat 5 of 16 -> all outputs at reset values immediately; leftover beats absorbed with m_rready=1; a new s1 request then completes correctly.
REQ-043 s1_rready held low for 3 cycles mid-burst -> m_rready=0 for those cycles and beat_cnt holds.
